lstm_job_scheduler: RTL and testbench

Front-end controller for the shared `LSTM` core. It serializes two requesters onto the single `iNext_valid`/`iType`/`iData` port: the syscall path (64-bit x vectors) and the branch path (512-bit vectors). It also streams parameter images (weights, biases, converter tables) from a byte-wide config memory onto the `iInit_*` port. It tracks `oLstm_done` to tell the owning requester when its result is valid on `oSys_Ht`/`oBr_Ht`.

---
 rtl/lstm_job_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_lstm_job_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_job_scheduler.sv
// Front-end controller for the shared LSTM core: arbitrates syscall/branch jobs
// onto the single compute port and streams parameter images onto the init port.
module lstm_job_scheduler #(
    parameter int unsigned SYS_W  = 64,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sys_valid,
    input  logic [SYS_W-1:0]  sys_data,
    output logic              sys_ready,
    input  logic              br_valid,
    input  logic [DATA_W-1:0] br_data,
    output logic              br_ready,
    input  logic              cfg_start,
    input  logic [2:0]        cfg_type,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_rd_en,
    output logic [LEN_W-1:0]  cfg_rd_addr,
    input  logic [7:0]        cfg_rd_data,
    output logic              oInit_valid,
    output logic [2:0]        oInit_type,
    output logic [7:0]        oInit_data,
    output logic              oNext_valid,
    output logic              oType,
    output logic [DATA_W-1:0] oData,
    input  logic              iLstm_done,
    output logic              res_valid,
    output logic              res_type
);

    localparam int unsigned TYPE_W      = 3;
    localparam logic [TYPE_W-1:0] INIT_IDLE = TYPE_W'(7);
    localparam logic [TYPE_W-1:0] MAX_TYPE  = TYPE_W'(5);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        DISPATCH,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t            state_q, state_nxt;
    logic              last_grant_q, last_grant_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic              rd_en_d1_q;

    logic              rd_en_nxt;
    logic [LEN_W-1:0]  addr_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              init_valid_nxt;
    logic [TYPE_W-1:0] init_type_nxt;
    logic [7:0]        init_data_nxt;
    logic              next_valid_nxt;
    logic              type_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              res_valid_nxt;
    logic              res_type_nxt;

    logic              cfg_accept;
    logic              grant_sys;

    // State and every output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            len_q        <= '0;
            rd_en_d1_q   <= 1'b0;
            cfg_rd_en    <= 1'b0;
            cfg_rd_addr  <= '0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            oInit_valid  <= 1'b0;
            oInit_type   <= INIT_IDLE;
            oInit_data   <= '0;
            oNext_valid  <= 1'b0;
            oType        <= 1'b0;
            oData        <= '0;
            res_valid    <= 1'b0;
            res_type     <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            last_grant_q <= last_grant_nxt;
            len_q        <= len_nxt;
            rd_en_d1_q   <= cfg_rd_en;
            cfg_rd_en    <= rd_en_nxt;
            cfg_rd_addr  <= addr_nxt;
            cfg_busy     <= busy_nxt;
            cfg_done     <= done_nxt;
            oInit_valid  <= init_valid_nxt;
            oInit_type   <= init_type_nxt;
            oInit_data   <= init_data_nxt;
            oNext_valid  <= next_valid_nxt;
            oType        <= type_nxt;
            oData        <= data_nxt;
            res_valid    <= res_valid_nxt;
            res_type     <= res_type_nxt;
        end
    end

    assign cfg_accept = cfg_start && (cfg_type <= MAX_TYPE);
    // Round robin: syscall wins a tie unless it was granted last
    assign grant_sys  = sys_valid && (!br_valid || !last_grant_q);

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state_q;
        last_grant_nxt = last_grant_q;
        len_nxt        = len_q;
        rd_en_nxt      = 1'b0;
        addr_nxt       = cfg_rd_addr;
        busy_nxt       = cfg_busy;
        done_nxt       = 1'b0;
        init_valid_nxt = rd_en_d1_q;
        init_type_nxt  = oInit_type;
        init_data_nxt  = rd_en_d1_q ? cfg_rd_data : oInit_data;
        next_valid_nxt = 1'b0;
        type_nxt       = oType;
        data_nxt       = oData;
        res_valid_nxt  = 1'b0;
        res_type_nxt   = res_type;
        sys_ready      = 1'b0;
        br_ready       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_accept) begin
                    len_nxt       = cfg_len;
                    init_type_nxt = cfg_type;
                    busy_nxt      = 1'b1;
                    addr_nxt      = '0;
                    if (cfg_len == '0) begin
                        state_nxt = DRAIN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        rd_en_nxt = 1'b1;
                    end
                end else if (iLstm_done && (sys_valid || br_valid)) begin
                    sys_ready      = grant_sys;
                    br_ready       = !grant_sys;
                    type_nxt       = grant_sys;
                    res_type_nxt   = grant_sys;
                    last_grant_nxt = grant_sys;
                    data_nxt       = grant_sys ? DATA_W'(sys_data) : br_data;
                    next_valid_nxt = 1'b1;
                    state_nxt      = DISPATCH;
                end
            end
            LOAD: begin
                if (cfg_rd_addr == len_q - LEN_W'(1)) begin
                    state_nxt = DRAIN;
                end else begin
                    addr_nxt  = cfg_rd_addr + LEN_W'(1);
                    rd_en_nxt = 1'b1;
                end
            end
            DRAIN: begin
                // Last byte has landed on oInit once the read pipe is empty
                if (cfg_done) begin
                    state_nxt     = IDLE;
                    busy_nxt      = 1'b0;
                    init_type_nxt = INIT_IDLE;
                end else if (!rd_en_d1_q && oInit_valid) begin
                    done_nxt = 1'b1;
                end
            end
            DISPATCH: begin
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!iLstm_done) begin
                    state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (iLstm_done) begin
                    state_nxt     = IDLE;
                    res_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lstm_job_scheduler.sv
// Directed testbench for lstm_job_scheduler: parameter loads, arbitration,
// dispatch/result handshake and asynchronous reset abort.
module tb_lstm_job_scheduler;

    localparam int unsigned SYS_W  = 64;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              sys_valid;
    logic [SYS_W-1:0]  sys_data;
    logic              sys_ready;
    logic              br_valid;
    logic [DATA_W-1:0] br_data;
    logic              br_ready;
    logic              cfg_start;
    logic [2:0]        cfg_type;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_rd_en;
    logic [LEN_W-1:0]  cfg_rd_addr;
    logic [7:0]        cfg_rd_data = 8'h00;
    logic              oInit_valid;
    logic [2:0]        oInit_type;
    logic [7:0]        oInit_data;
    logic              oNext_valid;
    logic              oType;
    logic [DATA_W-1:0] oData;
    logic              iLstm_done;
    logic              res_valid;
    logic              res_type;

    int checks = 0;
    int errors = 0;

    lstm_job_scheduler #(.SYS_W(SYS_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn),
        .sys_valid(sys_valid), .sys_data(sys_data), .sys_ready(sys_ready),
        .br_valid(br_valid), .br_data(br_data), .br_ready(br_ready),
        .cfg_start(cfg_start), .cfg_type(cfg_type), .cfg_len(cfg_len),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
        .oInit_valid(oInit_valid), .oInit_type(oInit_type), .oInit_data(oInit_data),
        .oNext_valid(oNext_valid), .oType(oType), .oData(oData),
        .iLstm_done(iLstm_done), .res_valid(res_valid), .res_type(res_type)
    );

    always #5 clk = ~clk;

    // Config memory: byte value equals low address byte, one cycle latency
    always @(posedge clk) begin
        if (cfg_rd_en) cfg_rd_data <= cfg_rd_addr[7:0];
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},      DATA_W'(cfg_busy),    '0);
        chk({tag, "_done"},      DATA_W'(cfg_done),    '0);
        chk({tag, "_rd_en"},     DATA_W'(cfg_rd_en),   '0);
        chk({tag, "_rd_addr"},   DATA_W'(cfg_rd_addr), '0);
        chk({tag, "_ivalid"},    DATA_W'(oInit_valid), '0);
        chk({tag, "_itype"},     DATA_W'(oInit_type),  DATA_W'(3'd7));
        chk({tag, "_idata"},     DATA_W'(oInit_data),  '0);
        chk({tag, "_nvalid"},    DATA_W'(oNext_valid), '0);
        chk({tag, "_otype"},     DATA_W'(oType),       '0);
        chk({tag, "_odata"},     oData,                '0);
        chk({tag, "_res_valid"}, DATA_W'(res_valid),   '0);
        chk({tag, "_res_type"},  DATA_W'(res_type),    '0);
    endtask

    // Starts a load in the current cycle C and checks every cycle up to the
    // first IDLE cycle; abort_k > 0 asserts reset inside cycle C+abort_k.
    task automatic run_load(input logic [2:0] t, input int len, input int abort_k);
        int last;
        cfg_start = 1'b1;
        cfg_type  = t;
        cfg_len   = LEN_W'(len);
        #1;
        chk("load_accept_sys_ready", DATA_W'(sys_ready), '0);
        step();
        cfg_start = 1'b0;
        last = (len == 0) ? 3 : len + 4;
        for (int k = 1; k <= last; k++) begin
            bit busy_e, rd_e, iv_e, done_e;
            if (len == 0) begin
                busy_e = (k == 1); rd_e = 1'b0; iv_e = 1'b0; done_e = (k == 1);
            end else begin
                busy_e = (k <= len + 3);
                rd_e   = (k <= len);
                iv_e   = (k >= 3) && (k <= len + 2);
                done_e = (k == len + 3);
            end
            chk("cfg_busy",    DATA_W'(cfg_busy),    DATA_W'(busy_e));
            chk("cfg_rd_en",   DATA_W'(cfg_rd_en),   DATA_W'(rd_e));
            chk("oInit_valid", DATA_W'(oInit_valid), DATA_W'(iv_e));
            chk("cfg_done",    DATA_W'(cfg_done),    DATA_W'(done_e));
            chk("oInit_type",  DATA_W'(oInit_type),  busy_e ? DATA_W'(t) : DATA_W'(3'd7));
            if (rd_e) chk("cfg_rd_addr", DATA_W'(cfg_rd_addr), DATA_W'(k - 1));
            if (iv_e) chk("oInit_data", DATA_W'(oInit_data), DATA_W'((k - 3) % 256));
            if (busy_e) chk("load_sys_ready", DATA_W'(sys_ready), '0);
            if (k == abort_k) begin
                resetn = 1'b0;
                #1;
                return;
            end
            if (k < last) step();
        end
    endtask

    // One job accepted in the current cycle A; done drops at A+2, rises at A+20
    task automatic job(input logic exp_sys, input logic [DATA_W-1:0] exp_data);
        #1;
        chk("job_sys_ready", DATA_W'(sys_ready), DATA_W'(exp_sys));
        chk("job_br_ready",  DATA_W'(br_ready),  DATA_W'(!exp_sys));
        step();
        chk("job_nvalid",   DATA_W'(oNext_valid), DATA_W'(1'b1));
        chk("job_otype",    DATA_W'(oType),       DATA_W'(exp_sys));
        chk("job_odata",    oData,                exp_data);
        chk("job_ready_a1", DATA_W'(sys_ready | br_ready), '0);
        step();
        chk("job_nvalid_a2", DATA_W'(oNext_valid), '0);
        iLstm_done = 1'b0;
        repeat (17) step();
        chk("job_res_early", DATA_W'(res_valid), '0);
        step();
        iLstm_done = 1'b1;
        chk("job_res_a20", DATA_W'(res_valid), '0);
        step();
        chk("job_res_valid", DATA_W'(res_valid), DATA_W'(1'b1));
        chk("job_res_type",  DATA_W'(res_type),  DATA_W'(exp_sys));
    endtask

    initial begin
        logic [DATA_W-1:0] sys_exp;
        resetn     = 1'b0;
        sys_valid  = 1'b0;
        sys_data   = '0;
        br_valid   = 1'b0;
        br_data    = '0;
        cfg_start  = 1'b0;
        cfg_type   = 3'd0;
        cfg_len    = '0;
        iLstm_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        resetn     = 1'b1;
        iLstm_done = 1'b1;
        step();

        // 512-byte load, then zero-length load
        run_load(3'd0, 512, 0);
        step();
        run_load(3'd5, 0, 0);

        // Reserved load type is ignored
        cfg_start = 1'b1; cfg_type = 3'd6; cfg_len = LEN_W'(4);
        step();
        cfg_start = 1'b0;
        chk("t6_busy",  DATA_W'(cfg_busy),   '0);
        chk("t6_rd_en", DATA_W'(cfg_rd_en),  '0);
        chk("t6_itype", DATA_W'(oInit_type), DATA_W'(3'd7));
        step();
        chk("t6_done",  DATA_W'(cfg_done),   '0);

        // Both requesters held: sys, br, sys, br
        sys_data = 64'hA5A5_0000_1111_2222;
        br_data  = {16{32'hDEAD_BEEF}};
        sys_exp  = {448'b0, 64'hA5A5_0000_1111_2222};
        sys_valid = 1'b1; br_valid = 1'b1;
        job(1'b1, sys_exp);
        job(1'b0, {16{32'hDEAD_BEEF}});
        job(1'b1, sys_exp);
        job(1'b0, {16{32'hDEAD_BEEF}});
        sys_valid = 1'b0; br_valid = 1'b0;
        step();
        chk("rr_res_drop", DATA_W'(res_valid), '0);

        // Lone syscall request
        sys_data  = 64'h0102_0304_0506_0708;
        sys_valid = 1'b1;
        job(1'b1, {448'b0, 64'h0102_0304_0506_0708});
        sys_valid = 1'b0;
        step();
        chk("sys_res_drop", DATA_W'(res_valid), '0);
        chk("sys_odata_hold", oData, {448'b0, 64'h0102_0304_0506_0708});

        // Config start beats a simultaneous syscall request
        sys_data  = 64'h0000_0000_CAFE_F00D;
        sys_valid = 1'b1;
        run_load(3'd2, 3, 0);
        job(1'b1, {448'b0, 64'h0000_0000_CAFE_F00D});
        sys_valid = 1'b0;
        step();

        // Reset while byte 10 of a 32-byte load is on oInit
        run_load(3'd1, 32, 13);
        chk_reset("rst_load");
        step();
        chk("rst_load_done1", DATA_W'(cfg_done), '0);
        resetn = 1'b1;
        step();
        chk("rst_load_done2", DATA_W'(cfg_done), '0);
        chk("rst_load_busy",  DATA_W'(cfg_busy), '0);

        // Reset while waiting for the LSTM result
        sys_data  = 64'h1234;
        sys_valid = 1'b1;
        step();
        sys_valid = 1'b0;
        step();
        iLstm_done = 1'b0;
        repeat (5) step();
        resetn = 1'b0;
        #1;
        chk_reset("rst_wait");
        iLstm_done = 1'b1;
        step();
        step();
        chk("rst_wait_res1", DATA_W'(res_valid), '0);
        resetn = 1'b1;
        step();
        chk("rst_wait_res2", DATA_W'(res_valid), '0);

        // Fresh load after reset, then tie goes to syscall again
        run_load(3'd3, 4, 0);
        sys_valid = 1'b1; br_valid = 1'b1;
        #1;
        chk("tie_sys_ready", DATA_W'(sys_ready), DATA_W'(1'b1));
        chk("tie_br_ready",  DATA_W'(br_ready),  '0);
        sys_valid = 1'b0; br_valid = 1'b0;
        step();
        chk("tie_no_dispatch", DATA_W'(oNext_valid), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
